// File: rtl/pll_lock_reset_if.sv
// pll_lock_reset_if: lock/reset control and status bundle between the PLL reset sequencer and its user
interface pll_lock_reset_if;
  logic       locked_i;
  logic       sw_reset_i;
  logic       clear_i;
  logic       rst_n_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [7:0] loss_count_o;
  modport master (
    output locked_i, sw_reset_i, clear_i,
    input  rst_n_o, ready_o, lock_lost_o, loss_count_o
  );
  modport slave (
    input  locked_i, sw_reset_i, clear_i,
    output rst_n_o, ready_o, lock_lost_o, loss_count_o
  );
endinterface

// File: rtl/pll_lock_reset.sv
// pll_lock_reset: qualifies PLL lock, sequences the downstream reset and tracks lock losses
module pll_lock_reset #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16
) (
  input logic             clk,
  input logic             resetn,
  pll_lock_reset_if.slave bus
);
  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STABLE    = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD_CYCLES - 1);
  logic        sync_q, lock_s_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rst_n_q;
  logic        lost_q, lost_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic        loss;
  // two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {sync_q, lock_s_q} <= 2'b00;
    else {sync_q, lock_s_q} <= {bus.locked_i, sync_q};
  // lock qualification and reset hold sequencing; any lock drop restarts from WAIT_LOCK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s_q) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: begin
        cnt_d = '0;
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (bus.sw_reset_i) state_d = HOLD;
      end
    endcase
  end
  // a loss is a lock drop seen while running; clear still lets a coincident loss register
  always_comb begin
    loss       = (state_q == RUN) && !lock_s_q;
    loss_cnt_d = bus.clear_i ? {7'd0, loss} : loss_cnt_q + {7'd0, loss && (loss_cnt_q != 8'hff)};
    lost_d     = loss | (lost_q & ~bus.clear_i);
  end
  // state, counters and the registered system reset, which is high exactly in RUN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      rst_n_q    <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_n_q    <= (state_d == RUN);
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end
  assign bus.rst_n_o      = rst_n_q;
  assign bus.ready_o      = rst_n_q;
  assign bus.lock_lost_o  = lost_q;
  assign bus.loss_count_o = loss_cnt_q;
endmodule
